// File: rtl/arb_static3_if.sv
// Request/acknowledge bundle between three clients and the static-priority arbiter.
interface arb_static3_if;
    logic [2:0] req;
    logic [2:0] ack;

    modport master (output req, input ack);
    modport slave  (input req, output ack);
endinterface

// File: rtl/arb_static3.sv
// Three-client static-priority arbiter (req[0] highest) with four-phase handshake;
// every handover passes through one IDLE cycle and grants are never preempted.
module arb_static3 (
    input  logic          clk,
    input  logic          rstn,
    arb_static3_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10,
        GNT2 = 2'b11
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ack_q, ack_d;

    // State and grant registers; rstn is an active-high asynchronous reset
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q <= IDLE;
            ack_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
        end
    end

    // Next-state arbitration and grant decode of the upcoming state
    always_comb begin
        state_d = state_q;
        ack_d   = 3'b000;
        case (state_q)
            IDLE: begin
                if (bus.req[0]) begin
                    state_d = GNT0;
                end else if (bus.req[1]) begin
                    state_d = GNT1;
                end else if (bus.req[2]) begin
                    state_d = GNT2;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0: begin
                if (bus.req[0]) begin
                    state_d = GNT0;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                if (bus.req[1]) begin
                    state_d = GNT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT2: begin
                if (bus.req[2]) begin
                    state_d = GNT2;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // ack is registered alongside the state so it always matches q's encoding
        case (state_d)
            IDLE:    ack_d = 3'b000;
            GNT0:    ack_d = 3'b001;
            GNT1:    ack_d = 3'b010;
            GNT2:    ack_d = 3'b100;
            default: ack_d = 3'b000;
        endcase
    end

    assign bus.ack = ack_q;

endmodule

// File: tb/tb_arb_static3.sv
// Self-checking bench for arb_static3: directed vector table, corner sequences and
// a randomised run against a scoreboard model plus invariant checks.
module tb_arb_static3;

    typedef struct {
        logic [2:0] req;
        logic [2:0] exp;
        string      nm;
    } vec_t;

    typedef struct {
        logic [2:0] exp;
        string      nm;
    } sb_t;

    logic clk;
    logic rstn;
    int   n_cmp;
    int   n_err;

    arb_static3_if bus ();

    arb_static3 dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    sb_t  exp_q[$];
    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: ack=%b expected=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] e, input string nm);
        vec_t v;
        v.req = r;
        v.exp = e;
        v.nm  = nm;
        tbl.push_back(v);
    endtask

    // Drive req between edges, queue the expectation, compare after the edge
    task automatic drive(input logic [2:0] r, input logic [2:0] e, input string nm);
        sb_t s;
        @(negedge clk);
        bus.req = r;
        s.exp = e;
        s.nm  = nm;
        exp_q.push_back(s);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            s = exp_q.pop_front();
            check(s.nm, bus.ack, s.exp);
        end
    endtask

    function automatic logic [2:0] onehot_of(input int g);
        logic [2:0] r;
        case (g)
            0:       r = 3'b001;
            1:       r = 3'b010;
            2:       r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    initial begin
        int          g;
        logic [2:0]  r;
        logic [2:0]  e;
        logic [2:0]  prev_ack;
        logic [1:0]  enc;
        n_cmp = 0;
        n_err = 0;

        // Reset held for 13 ns with all requests high
        rstn    = 1'b1;
        bus.req = 3'b111;
        #1;  check("reset_t1",  bus.ack, 3'b000);
        #5;  check("reset_t6",  bus.ack, 3'b000);
        #6;  check("reset_t12", bus.ack, 3'b000);
        n_cmp++;
        if ($isunknown(bus.ack)) begin
            n_err++;
            $display("FAIL reset_x: ack=%b expected=000", bus.ack);
        end
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("first_edge", bus.ack, 3'b001);

        // Directed vectors: {req driven before edge, ack expected after it}
        add(3'b000, 3'b000, "back_idle");
        add(3'b100, 3'b100, "single_grant");
        for (int i = 0; i < 5; i++) add(3'b100, 3'b100, "single_hold");
        add(3'b000, 3'b000, "single_release");
        add(3'b111, 3'b001, "simul_win0");
        add(3'b110, 3'b000, "simul_gap0");
        add(3'b110, 3'b010, "simul_win1");
        add(3'b100, 3'b000, "simul_gap1");
        add(3'b100, 3'b100, "simul_win2");
        add(3'b000, 3'b000, "simul_end");
        add(3'b100, 3'b100, "nopre_grant");
        add(3'b101, 3'b100, "nopre_hold_a");
        add(3'b101, 3'b100, "nopre_hold_b");
        add(3'b001, 3'b000, "nopre_gap");
        add(3'b001, 3'b001, "nopre_win0");
        add(3'b000, 3'b000, "nopre_end");
        add(3'b010, 3'b010, "rereq_grant");
        add(3'b000, 3'b000, "rereq_drop");
        add(3'b010, 3'b010, "rereq_again");
        add(3'b100, 3'b000, "swap_gap");
        add(3'b100, 3'b100, "swap_win2");
        add(3'b011, 3'b000, "same_edge_gap");
        add(3'b011, 3'b001, "same_edge_win0");
        add(3'b000, 3'b000, "table_end");
        foreach (tbl[k]) drive(tbl[k].req, tbl[k].exp, tbl[k].nm);

        // Reset mid-grant: ack must fall before the next edge, then re-grant
        drive(3'b010, 3'b010, "mid_grant");
        @(negedge clk);
        #2;
        rstn = 1'b1;
        #1;
        check("mid_reset_async", bus.ack, 3'b000);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("mid_reset_regrant", bus.ack, 3'b010);
        drive(3'b000, 3'b000, "mid_reset_release");

        // Random run: scoreboard model plus per-cycle invariants
        g        = -1;
        prev_ack = 3'b000;
        for (int c = 0; c < 1200; c++) begin
            r = 3'($urandom_range(0, 7));
            if (g < 0) begin
                if (r[0])      g = 0;
                else if (r[1]) g = 1;
                else if (r[2]) g = 2;
            end else if (!r[g]) begin
                g = -1;
            end
            e = onehot_of(g);
            drive(r, e, "rand_model");
            n_cmp++;
            if (!$onehot0(bus.ack)) begin
                n_err++;
                $display("FAIL rand_onehot: ack=%b expected one-hot or 000", bus.ack);
            end
            n_cmp++;
            if ((bus.ack & ~r) != 3'b000) begin
                n_err++;
                $display("FAIL rand_req_implied: ack=%b req=%b expected ack within req", bus.ack, r);
            end
            n_cmp++;
            if (bus.ack != 3'b000 && prev_ack != 3'b000 && bus.ack != prev_ack) begin
                n_err++;
                $display("FAIL rand_gap: ack=%b after %b expected 000 between", bus.ack, prev_ack);
            end
            case (bus.ack)
                3'b001:  enc = 2'b01;
                3'b010:  enc = 2'b10;
                3'b100:  enc = 2'b11;
                default: enc = 2'b00;
            endcase
            n_cmp++;
            if (dut.state_q != enc) begin
                n_err++;
                $display("FAIL rand_q_enc: q=%b expected=%b", dut.state_q, enc);
            end
            prev_ack = bus.ack;
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
